// File: rtl/quad_operand_driver.sv
// Operand-load initiator for the quadratic evaluator: serializes A, B, C, X as
// data/go pulses, waits out the compute time, then captures the evaluator result.
module quad_operand_driver #(
  parameter int DATA_W      = 8,
  parameter int GO_CYCLES   = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int RESULT_WAIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_c,
  input  logic [DATA_W-1:0] op_x,
  input  logic [DATA_W-1:0] data_result_in,
  output logic [DATA_W-1:0] data_out,
  output logic              go_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int MAX_CNT = (GO_CYCLES > GAP_CYCLES)
                           ? ((GO_CYCLES > RESULT_WAIT) ? GO_CYCLES : RESULT_WAIT)
                           : ((GAP_CYCLES > RESULT_WAIT) ? GAP_CYCLES : RESULT_WAIT);
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  typedef enum logic [2:0] {IDLE, SETUP, GO_HI, GO_LO, WAIT_RES} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [1:0]          idx, idx_nxt;
  logic                last;
  logic [DATA_W-1:0]   opr [4];
  logic                accept;
  logic [DATA_W-1:0]   data_nxt, result_nxt;
  logic                go_nxt, busy_nxt, done_nxt;

  assign accept = (state == IDLE) && start;

  // last cycle of the current timed state
  always_comb begin
    last = 1'b0;
    unique case (state)
      GO_HI:    last = (cnt == CNT_W'(GO_CYCLES - 1));
      GO_LO:    last = (cnt == CNT_W'(GAP_CYCLES - 1));
      WAIT_RES: last = (cnt == CNT_W'(RESULT_WAIT - 1));
      default:  last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      for (int k = 0; k < 4; k++) opr[k] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        opr[0] <= op_a;
        opr[1] <= op_b;
        opr[2] <= op_c;
        opr[3] <= op_x;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = SETUP;
        idx_nxt   = 2'd0;
      end
      SETUP:    state_nxt = GO_HI;
      GO_HI:    if (last) state_nxt = GO_LO;
      GO_LO: if (last) begin
        if (idx == 2'd3) state_nxt = WAIT_RES;
        else begin
          state_nxt = SETUP;
          idx_nxt   = idx + 2'd1;
        end
      end
      WAIT_RES: if (last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt != state) ? '0 : cnt + 1'b1;
  end

  // next values of the registered outputs, derived from the transition being taken
  always_comb begin
    data_nxt   = data_out;
    result_nxt = result;
    done_nxt   = 1'b0;
    if (accept)
      data_nxt = op_a;
    else if ((state == GO_LO) && last && (idx != 2'd3))
      data_nxt = opr[idx + 2'd1];
    if ((state == WAIT_RES) && last) begin
      result_nxt = data_result_in;
      done_nxt   = 1'b1;
    end
    go_nxt   = (state_nxt == GO_HI);
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_out <= '0;
      go_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      data_out <= data_nxt;
      go_out   <= go_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      result   <= result_nxt;
    end
  end

endmodule

// File: tb/tb_quad_operand_driver.sv
// Bench for quad_operand_driver: two parameterizations, each paired with an
// evaluator stand-in, checked every cycle against a timeline model.
module tb_quad_operand_driver;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0, op_b = '0, op_c = '0, op_x = '0;
  logic [7:0] dout [2];
  logic [7:0] res  [2];
  logic [7:0] sres [2];
  logic       go   [2];
  logic       bsy  [2];
  logic       dn   [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  quad_operand_driver #(.DATA_W(8), .GO_CYCLES(2), .GAP_CYCLES(2), .RESULT_WAIT(8)) dut0 (
    .clk(clk), .resetn(resetn), .start(start),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x),
    .data_result_in(sres[0]), .data_out(dout[0]), .go_out(go[0]),
    .busy(bsy[0]), .done(dn[0]), .result(res[0]));

  quad_operand_driver #(.DATA_W(8), .GO_CYCLES(1), .GAP_CYCLES(3), .RESULT_WAIT(4)) dut1 (
    .clk(clk), .resetn(resetn), .start(start),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x),
    .data_result_in(sres[1]), .data_out(dout[1]), .go_out(go[1]),
    .busy(bsy[1]), .done(dn[1]), .result(res[1]));

  function automatic int p_go(int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int p_gap(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int p_rw(int i);  return (i == 0) ? 8 : 4; endfunction
  function automatic int p_per(int i); return 1 + p_go(i) + p_gap(i); endfunction
  function automatic int p_len(int i); return 4 * p_per(i) + p_rw(i) + 1; endfunction

  function automatic logic [7:0] quad(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] x);
    logic [31:0] r;
    r = a * x * x + b * x + c;
    return r[7:0];
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // evaluator stand-in: loads one operand per go pulse, answers a few cycles after X
  logic [7:0] sa [2][4];
  int         scnt [2];
  int         sdly [2];
  logic       gprev [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        scnt[i] <= 0; sdly[i] <= 0; gprev[i] <= 1'b0; sres[i] <= '0;
        for (int k = 0; k < 4; k++) sa[i][k] <= '0;
      end else begin
        gprev[i] <= go[i];
        if (sdly[i] > 0) sdly[i] <= sdly[i] - 1;
        if (sdly[i] == 1) sres[i] <= quad(sa[i][0], sa[i][1], sa[i][2], sa[i][3]);
        if (go[i] && !gprev[i]) begin
          sa[i][scnt[i]] <= dout[i];
          scnt[i] <= (scnt[i] == 3) ? 0 : scnt[i] + 1;
          if (scnt[i] == 3) sdly[i] <= 4;
        end
      end
    end
  end

  // timeline model: mt = cycles since acceptance (0 = idle)
  int         mt  [2];
  logic [7:0] mop [2][4];
  logic [7:0] mres [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        mt[i] <= 0; mres[i] <= '0;
        for (int k = 0; k < 4; k++) mop[i][k] <= '0;
      end else if ((mt[i] == 0 || mt[i] == p_len(i)) && start) begin
        mt[i] <= 1;
        mop[i][0] <= op_a; mop[i][1] <= op_b; mop[i][2] <= op_c; mop[i][3] <= op_x;
      end else if (mt[i] == p_len(i)) begin
        mt[i] <= 0;
      end else if (mt[i] > 0) begin
        mt[i] <= mt[i] + 1;
        if (mt[i] + 1 == p_len(i)) mres[i] <= quad(mop[i][0], mop[i][1], mop[i][2], mop[i][3]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int t, per, r;
        logic [7:0] ed;
        logic eg;
        t   = mt[i];
        per = p_per(i);
        r   = (t - 1) % per;
        ed  = (t >= 1 && t <= 4 * per) ? mop[i][(t - 1) / per] : mop[i][3];
        eg  = (t >= 1 && t <= 4 * per && r >= 1 && r <= p_go(i));
        chk($sformatf("inst%0d data_out t=%0d", i, t), dout[i], ed);
        chk($sformatf("inst%0d go_out t=%0d", i, t), go[i], eg);
        chk($sformatf("inst%0d busy t=%0d", i, t), bsy[i], (t >= 1 && t < p_len(i)));
        chk($sformatf("inst%0d done t=%0d", i, t), dn[i], (t == p_len(i)));
        chk($sformatf("inst%0d result t=%0d", i, t), res[i], mres[i]);
      end
    end
  end

  // one accepted run; optional lockout starts, operand scrambling, mid-run reset
  task automatic run(input logic [7:0] a, b, c, x, input int exp_res,
                     input bit lock, input bit scramble, input int rst_at, input string tag);
    int n;
    int dc [2];
    int gp [2];
    logic pg [2];
    @(negedge clk);
    op_a = a; op_b = b; op_c = c; op_x = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    for (int i = 0; i < 2; i++) begin dc[i] = -1; gp[i] = 0; pg[i] = 1'b0; end
    while ((dc[0] < 0 || dc[1] < 0) && n < 80) begin
      for (int i = 0; i < 2; i++) begin
        if (dc[i] < 0 && go[i] && !pg[i]) gp[i]++;
        pg[i] = go[i];
        if (dn[i] && dc[i] < 0) dc[i] = n;
      end
      if (rst_at == n) begin
        resetn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("%s inst%0d data_out", tag, i), dout[i], 0);
          chk($sformatf("%s inst%0d go_out", tag, i), go[i], 0);
          chk($sformatf("%s inst%0d busy", tag, i), bsy[i], 0);
          chk($sformatf("%s inst%0d done", tag, i), dn[i], 0);
          chk($sformatf("%s inst%0d result", tag, i), res[i], 0);
        end
        resetn = 1'b1;
        return;
      end
      if (scramble) begin
        op_a = 8'($urandom); op_b = 8'($urandom); op_c = 8'($urandom); op_x = 8'($urandom);
      end
      if (lock && (n == 5 || n == 20)) begin
        start = 1'b1;
        op_a = a + 8'd7; op_b = b ^ 8'h55; op_c = c + 8'd1; op_x = x + 8'd3;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " inst0 done cycle"}, dc[0], 29);
    chk({tag, " inst1 done cycle"}, dc[1], 25);
    chk({tag, " inst0 result"}, res[0], exp_res);
    chk({tag, " inst1 result"}, res[1], exp_res);
    chk({tag, " inst0 go pulses"}, gp[0], 4);
    chk({tag, " inst1 go pulses"}, gp[1], 4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset inst%0d data_out", i), dout[i], 0);
      chk($sformatf("reset inst%0d go_out", i), go[i], 0);
      chk($sformatf("reset inst%0d busy", i), bsy[i], 0);
      chk($sformatf("reset inst%0d done", i), dn[i], 0);
      chk($sformatf("reset inst%0d result", i), res[i], 0);
    end
    chk_en = 1'b1;
    resetn = 1'b1;

    run(8'd1, 8'd2, 8'd3, 8'd4, 27, 1'b0, 1'b0, 0, "nominal");
    run(8'd3, 8'd0, 8'd0, 8'd10, 8'h2C, 1'b0, 1'b0, 0, "wrap");
    run(8'd0, 8'd0, 8'hFF, 8'd0, 8'hFF, 1'b0, 1'b0, 0, "const_ff");
    run(8'd5, 8'd6, 8'd7, 8'd2, 39, 1'b1, 1'b0, 0, "lockout");
    run(8'd9, 8'd1, 8'd4, 8'd3, 88, 1'b0, 1'b1, 0, "hold");
    run(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0, 1'b0, 12, "midreset");
    run(8'd2, 8'd0, 8'd1, 8'd3, 8'h13, 1'b0, 1'b0, 0, "after_reset");
    run(8'd1, 8'd1, 8'd1, 8'd1, 3, 1'b0, 1'b0, 0, "ones");

    // randomized traffic: starts at any time, shifting operands, rare resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start  = ($urandom_range(3) == 0);
      op_a = 8'($urandom); op_b = 8'($urandom); op_c = 8'($urandom); op_x = 8'($urandom);
      resetn = ($urandom_range(399) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
